mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
//
// PURPOSE
//   Memory-mapped UART transmitter on the data-memory port, downstream of the memory access unit.
//   Decodes the store address, byte enables and data issued in the ME stage.
//   Queues transmitted bytes in a FIFO and serialises them 8N1 on a single TX line.
//   Lets CPU programs emit console/debug output with ordinary SB/SW instructions and poll a status word.
//
// PARAMETERS
//   ADDR_WIDTH    13       width of the dmem word address compared against the register addresses
//   DATA_WIDTH    32       store/load data width
//   CLKS_PER_BIT  868      sysclk cycles per UART bit (100 MHz / 115200); legal range >= 2
//   FIFO_DEPTH    16       TX FIFO entries; must be a power of two, >= 2
//   TXDATA_ADDR   13'h1FFF TX data register address (write only)
//   STATUS_ADDR   13'h1FFE status register address (read only)
//
// PORTS
//   sysclk   in   1           system clock, all logic on posedge
//   rst      in   1           synchronous, active-high reset
//   addr     in   ADDR_WIDTH  dmem address from the memory access unit
//   wr_mode  in   4           byte write enables; wr_mode[0] qualifies a TXDATA write
//   wdata    in   DATA_WIDTH  store data; byte [7:0] is transmitted
//   rd_en    in   1           load strobe for the current addr
//   rdata    out  DATA_WIDTH  registered read data
//   tx       out  1           serial output, idle high
//   busy     out  1           high while a frame is shifting or the FIFO is non-empty
//
// BEHAVIOUR
//   - Reset (sync, active-high, sampled on the sysclk edge):
//     tx=1, busy=0, rdata=0, FIFO empty, overflow=0, FSM=IDLE, bit/baud counters=0.
//   - Reset mid-frame aborts the frame; tx is high from the first edge with rst=1.
//   - Push: addr==TXDATA_ADDR && wr_mode[0] pushes wdata[7:0] on that edge.
//     If the FIFO is full and no pop happens that edge, the byte is dropped and overflow is set (sticky).
//   - Simultaneous push+pop on a full FIFO: both occur; count stays FIFO_DEPTH; no overflow.
//   - A pop never occurs on an empty FIFO, so a push into an empty FIFO is popped at the next edge at the earliest.
//   - Read: rd_en && addr==STATUS_ADDR, one-cycle latency:
//     rdata <= {28'b0, overflow, tx_busy, empty, full}.
//     The same edge clears overflow unless an overflow occurs that cycle, in which case overflow stays 1.
//   - Any other read, or no read: rdata <= 0. TXDATA reads return 0.
//   - FSM (tx is registered, so each state drives it from the edge of entry):
//     - IDLE:  tx=1. When the FIFO is non-empty, pop into shift_reg, go to START.
//     - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//     - DATA:  tx=shift_reg[bit_idx], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP
//       (PARITY if UART_TX_PARITY_EN).
//     - STOP:  tx=1 for CLKS_PER_BIT cycles, then IDLE. Back-to-back bytes leave a single IDLE cycle between frames.
//   - Latency: TXDATA write at edge N -> FIFO count 1 after N -> pop and tx=0 after N+1.
//   - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on every state or bit advance.
//   - FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap is natural modulo; full when the pointer MSBs differ and the rest are equal.
//   - busy = (state!=IDLE) || !empty. tx_busy in the status word = (state!=IDLE).
//
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - Adds a PARITY state between DATA and STOP driving ^shift_reg[7:0] (even parity) for CLKS_PER_BIT cycles.
//     - Frame = 11 bits.
//   Undefined: no PARITY state; 10-bit 8N1 frame; logic absent from the netlist.
//
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. Reset held 3 cycles -> tx=1, busy=0, rdata=0. STATUS read -> rdata=32'h2 (empty).
//   2. SB 8'hA5 to TXDATA -> tx low 2 edges later. Line sequence 0,1,0,1,0,0,1,0,1, each held 4 cycles.
//      busy falls after 40 cycles of frame.
//   3. Store to TXDATA with wr_mode=4'b0010 -> no push; FIFO stays empty; tx stays 1.
//   4. 6 back-to-back pushes 8'h01..8'h06 while idle -> first popped, next 4 fill FIFO, 6th dropped.
//      STATUS shows full=1, overflow=1 (rdata=32'hD). Second STATUS read shows overflow=0.
//      Bytes 01..05 are transmitted.
//   5. rst asserted mid-DATA of 8'hFF -> tx=1 the next edge, FIFO empty.
//      A new byte 8'h3C after reset transmits cleanly.
//   6. With UART_TX_PARITY_EN: byte 8'h07 -> parity bit 1 before stop; frame lasts 44 cycles.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO and a polled status word.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module mmio_uart_tx #(
    parameter int unsigned            ADDR_WIDTH   = 13,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            CLKS_PER_BIT = 868,
    parameter int unsigned            FIFO_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0]  TXDATA_ADDR  = 13'h1FFF,
    parameter logic [ADDR_WIDTH-1:0]  STATUS_ADDR  = 13'h1FFE
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            wr_mode,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  tx,
    output logic                  busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    tx_q, tx_d;
    logic [7:0]              shift_q, shift_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]        baud_q, baud_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [7:0]              mem_q [FIFO_DEPTH];

    logic empty_s, full_s, push_req_s, pop_s, push_s, ovf_evt_s, stat_rd_s, baud_done_s;
    logic unused_bits_s;

    assign unused_bits_s = ^{wdata[DATA_WIDTH-1:8], wr_mode[3:1]};

    // Full when the pointers have lapped each other: MSBs differ, index bits equal.
    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign full_s      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                         (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign push_req_s  = (addr == TXDATA_ADDR) && wr_mode[0];
    assign pop_s       = (state_q == ST_IDLE) && !empty_s;
    assign push_s      = push_req_s && (!full_s || pop_s);
    assign ovf_evt_s   = push_req_s && full_s && !pop_s;
    assign stat_rd_s   = rd_en && (addr == STATUS_ADDR);
    assign baud_done_s = (baud_q == BAUD_LAST);

    assign tx    = tx_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != ST_IDLE) || !empty_s;

    // FIFO pointers, sticky overflow flag and status read-back.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        rdata_d    = {DATA_WIDTH{1'b0}};
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (ovf_evt_s) begin
            overflow_d = 1'b1;
        end else if (stat_rd_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (stat_rd_s) begin
            rdata_d = {{(DATA_WIDTH-4){1'b0}}, overflow_q, (state_q != ST_IDLE), empty_s, full_s};
        end else begin
            rdata_d = {DATA_WIDTH{1'b0}};
        end
    end

    // Frame sequencer; tx_d is the line level for the state being entered.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = {CNT_W{1'b0}};
                if (!empty_s) begin
                    shift_d = mem_q[rd_ptr_q[PTR_W-2:0]];
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_done_s) begin
                    baud_d    = {CNT_W{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[bit_idx_q];
                if (baud_done_s) begin
                    baud_d = {CNT_W{1'b0}};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = ^shift_q;
                if (baud_done_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_done_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                baud_d  = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            baud_q     <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            overflow_q <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge sysclk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= wdata[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed stimulus checked every cycle against a
// queue-and-frame-timeline reference model of the transmitter.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [12:0] TXA = 13'h1FFF;
    localparam logic [12:0] STA = 13'h1FFE;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        sysclk = 1'b0;
    logic        rst;
    logic [12:0] addr;
    logic [3:0]  wr_mode;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    always #5 sysclk = ~sysclk;

    mmio_uart_tx #(
        .ADDR_WIDTH(13), .DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
        .TXDATA_ADDR(TXA), .STATUS_ADDR(STA)
    ) dut (
        .sysclk(sysclk), .rst(rst), .addr(addr), .wr_mode(wr_mode), .wdata(wdata),
        .rd_en(rd_en), .rdata(rdata), .tx(tx), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: pending bytes, frame in flight and elapsed cycles in that frame
    logic [7:0]  q [$];
    logic [7:0]  cur;
    bit          active;
    int          t;
    bit          ovf;
    logic [31:0] exp_rdata;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        else if (idx == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic [12:0] a, input logic [3:0] wm,
                              input logic [31:0] wd, input logic re);
        bit full, empty, req, popn, sr, pre_active;
        if (r) begin
            q.delete();
            active    = 0;
            t         = 0;
            ovf       = 0;
            exp_rdata = 32'h0;
        end else begin
            full       = (q.size() == DEPTH);
            empty      = (q.size() == 0);
            pre_active = active;
            req        = (a == TXA) && wm[0];
            popn       = !active && !empty;
            sr         = re && (a == STA);
            exp_rdata  = sr ? {28'h0, ovf, pre_active, empty, full} : 32'h0;
            if (req && full && !popn) ovf = 1;
            else if (sr) ovf = 0;
            if (active) begin
                t++;
                if (t == NBITS * CPB) active = 0;
            end else if (popn) begin
                cur    = q.pop_front();
                active = 1;
                t      = 0;
            end
            if (req && (!full || popn)) q.push_back(wd[7:0]);
        end
    endtask

    task automatic cycle(input logic r, input logic [12:0] a, input logic [3:0] wm,
                         input logic [31:0] wd, input logic re);
        rst = r; addr = a; wr_mode = wm; wdata = wd; rd_en = re;
        @(posedge sysclk);
        model_step(r, a, wm, wd, re);
        #1;
        check_val("tx", {31'h0, tx}, {31'h0, (active ? frame_bit(cur, t / CPB) : 1'b1)});
        check_val("busy", {31'h0, busy}, {31'h0, (active || q.size() > 0)});
        check_val("rdata", rdata, exp_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 13'h0000, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic push(input logic [7:0] b, input logic [3:0] wm);
        cycle(1'b0, TXA, wm, {$urandom, b} , 1'b0);
    endtask

    task automatic status_read();
        cycle(1'b0, STA, 4'h0, 32'h0, 1'b1);
    endtask

    initial begin
        active = 0; t = 0; ovf = 0; cur = 8'h00; exp_rdata = 32'h0;
        // 1: reset state and empty status
        for (int i = 0; i < 3; i++) cycle(1'b1, 13'h0000, 4'h0, 32'h0, 1'b0);
        check_val("reset_tx", {31'h0, tx}, 32'h1);
        check_val("reset_busy", {31'h0, busy}, 32'h0);
        check_val("reset_rdata", rdata, 32'h0);
        status_read();
        check_val("status_empty", rdata, 32'h2);

        // 2: single byte A5
        push(8'hA5, 4'b0001);
        check_val("a5_tx_before_pop", {31'h0, tx}, 32'h1);
        idle(1);
        check_val("a5_start_bit", {31'h0, tx}, 32'h0);
        idle(NBITS * CPB + 4);
        check_val("a5_done_busy", {31'h0, busy}, 32'h0);

        // 3: byte lane 1 only, no push
        push(8'h77, 4'b0010);
        idle(3);
        check_val("no_push_busy", {31'h0, busy}, 32'h0);
        check_val("no_push_tx", {31'h0, tx}, 32'h1);

        // 4: overflow with six back-to-back pushes
        for (int i = 1; i <= 6; i++) push(8'(i), 4'b1111);
        status_read();
        check_val("status_full_ovf", rdata, 32'hD);
        status_read();
        check_val("status_ovf_cleared", rdata, 32'h5);
        cycle(1'b0, TXA, 4'h0, 32'h0, 1'b1);
        check_val("txdata_read_zero", rdata, 32'h0);
        idle(6 * NBITS * CPB);

        // 5: reset mid-DATA, then a clean byte
        push(8'hFF, 4'b0001);
        idle(1 + CPB + 2 * CPB);
        cycle(1'b1, 13'h0000, 4'h0, 32'h0, 1'b0);
        check_val("midframe_rst_tx", {31'h0, tx}, 32'h1);
        check_val("midframe_rst_busy", {31'h0, busy}, 32'h0);
        push(8'h3C, 4'b0001);
        idle(NBITS * CPB + 4);

        // 6: parity-sensitive byte
        push(8'h07, 4'b0001);
        idle(NBITS * CPB + 4);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            int op;
            op = $urandom_range(0, 99);
            if ($urandom_range(0, 999) == 0) begin
                cycle(1'b1, 13'h0000, 4'h0, 32'h0, 1'b0);
            end else if (i % 700 == 0) begin
                for (int k = 0; k < 6; k++) push(8'($urandom), 4'($urandom));
            end else if (op < 3) begin
                push(8'($urandom), 4'($urandom));
            end else if (op < 7) begin
                status_read();
            end else if (op < 10) begin
                cycle(1'b0, 13'($urandom), 4'($urandom), $urandom, 1'($urandom));
            end else begin
                idle(1);
            end
        end
        idle(8 * NBITS * CPB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
